// File: rtl/pll_lock_reset_seq.sv
// rtl/pll_lock_reset_seq.sv - PLL lock synchroniser/filter with downstream reset and SDRAM init sequencing
module pll_lock_reset_seq #(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_CYCLES = 64,
  parameter int HOLD_CYCLES = 16,
  parameter int INIT_CYCLES = 5400,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             lock,
  input  logic             clr_lost,
  output logic             rst_out,
  output logic             init_done,
  output logic             locked,
  output logic             lock_lost,
  output logic [CNT_W-1:0] relock_cnt
);

  localparam int MAX_A = (FILT_CYCLES > HOLD_CYCLES) ? FILT_CYCLES : HOLD_CYCLES;
  localparam int MAX_C = (MAX_A > INIT_CYCLES) ? MAX_A : INIT_CYCLES;
  localparam int CW    = (MAX_C > 1) ? $clog2(MAX_C + 1) : 1;

  localparam logic [CW-1:0] FILT_LAST = CW'(FILT_CYCLES - 1);
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] INIT_LAST = CW'(INIT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_WAIT_LOCK = 3'd0,
    S_FILTER    = 3'd1,
    S_HOLD      = 3'd2,
    S_INIT      = 3'd3,
    S_RUN       = 3'd4
  } state_t;

  state_t                   state, state_nxt;
  logic [CW-1:0]            cnt, cnt_nxt;
  logic [SYNC_STAGES-1:0]   sync_q;
  logic                     lock_s;
  logic                     run_loss;
  logic                     rst_out_nxt, init_done_nxt, locked_nxt, lock_lost_nxt;
  logic [CNT_W-1:0]         relock_cnt_nxt;

  assign lock_s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], lock};
    end
  end

  // Outputs are registered from their next-state decode so they change on the same edge as state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_WAIT_LOCK;
      cnt        <= '0;
      rst_out    <= 1'b1;
      init_done  <= 1'b0;
      locked     <= 1'b0;
      lock_lost  <= 1'b0;
      relock_cnt <= '0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      rst_out    <= rst_out_nxt;
      init_done  <= init_done_nxt;
      locked     <= locked_nxt;
      lock_lost  <= lock_lost_nxt;
      relock_cnt <= relock_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      S_WAIT_LOCK: begin
        if (lock_s) begin
          state_nxt = S_FILTER;
          cnt_nxt   = '0;
        end
      end
      S_FILTER: begin
        if (!lock_s) begin
          state_nxt = S_WAIT_LOCK;
          cnt_nxt   = '0;
        end else if (cnt == FILT_LAST) begin
          state_nxt = S_HOLD;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      S_HOLD: begin
        if (!lock_s) begin
          state_nxt = S_WAIT_LOCK;
          cnt_nxt   = '0;
        end else if (cnt == HOLD_LAST) begin
          state_nxt = S_INIT;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      S_INIT: begin
        if (!lock_s) begin
          state_nxt = S_WAIT_LOCK;
          cnt_nxt   = '0;
        end else if (cnt == INIT_LAST) begin
          state_nxt = S_RUN;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      S_RUN: begin
        if (!lock_s) begin
          state_nxt = S_WAIT_LOCK;
          cnt_nxt   = '0;
        end
      end
      default: begin
        state_nxt = S_WAIT_LOCK;
        cnt_nxt   = '0;
      end
    endcase
  end

  // A loss landing in the same cycle as clr_lost keeps lock_lost set.
  always_comb begin
    run_loss       = (state == S_RUN) && !lock_s;
    rst_out_nxt    = !((state_nxt == S_INIT) || (state_nxt == S_RUN));
    init_done_nxt  = (state_nxt == S_RUN);
    locked_nxt     = (state_nxt == S_HOLD) || (state_nxt == S_INIT) || (state_nxt == S_RUN);
    lock_lost_nxt  = lock_lost;
    relock_cnt_nxt = relock_cnt;
    if (run_loss) begin
      lock_lost_nxt = 1'b1;
      if (relock_cnt != {CNT_W{1'b1}}) begin
        relock_cnt_nxt = relock_cnt + CNT_W'(1);
      end
    end else if (clr_lost) begin
      lock_lost_nxt = 1'b0;
    end
  end

endmodule

// File: tb/tb_pll_lock_reset_seq.sv
// tb/tb_pll_lock_reset_seq.sv - directed self-checking bench for pll_lock_reset_seq
module tb_pll_lock_reset_seq;

  logic       clk;
  logic       rst;
  logic       lock;
  logic       clr_lost;
  logic       rst_out;
  logic       init_done;
  logic       locked;
  logic       lock_lost;
  logic [7:0] relock_cnt;

  int checks = 0;
  int errors = 0;

  pll_lock_reset_seq #(
    .SYNC_STAGES(2),
    .FILT_CYCLES(8),
    .HOLD_CYCLES(4),
    .INIT_CYCLES(20),
    .CNT_W(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .lock(lock),
    .clr_lost(clr_lost),
    .rst_out(rst_out),
    .init_done(init_done),
    .locked(locked),
    .lock_lost(lock_lost),
    .relock_cnt(relock_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    lock = 1'b0;
    clr_lost = 1'b0;
    tick(2);
    rst = 1'b0;
  endtask

  task automatic wait_init(input string tag);
    int n;
    n = 0;
    while (!init_done && n < 80) begin
      tick(1);
      n++;
    end
    chk(tag, {31'd0, init_done}, 32'd1);
  endtask

  initial begin
    rst = 1'b1;
    lock = 1'b0;
    clr_lost = 1'b0;
    tick(2);
    chk("rst_rst_out", {31'd0, rst_out}, 32'd1);
    chk("rst_init_done", {31'd0, init_done}, 32'd0);
    chk("rst_locked", {31'd0, locked}, 32'd0);
    chk("rst_lock_lost", {31'd0, lock_lost}, 32'd0);
    chk("rst_relock_cnt", {24'd0, relock_cnt}, 32'd0);
    rst = 1'b0;

    // Test 1: stable lock, 15-cycle release and 20-cycle init
    lock = 1'b1;
    tick(10);
    chk("t1_locked_early", {31'd0, locked}, 32'd0);
    tick(1);
    chk("t1_locked_set", {31'd0, locked}, 32'd1);
    tick(3);
    chk("t1_rst_out_held", {31'd0, rst_out}, 32'd1);
    tick(1);
    chk("t1_rst_out_fall", {31'd0, rst_out}, 32'd0);
    tick(19);
    chk("t1_init_early", {31'd0, init_done}, 32'd0);
    tick(1);
    chk("t1_init_done", {31'd0, init_done}, 32'd1);
    chk("t1_locked_run", {31'd0, locked}, 32'd1);

    // Test 3: loss in RUN for 10 clocks, then relock
    lock = 1'b0;
    tick(2);
    chk("t3_rst_out_still0", {31'd0, rst_out}, 32'd0);
    tick(1);
    chk("t3_rst_out_rise", {31'd0, rst_out}, 32'd1);
    chk("t3_lock_lost", {31'd0, lock_lost}, 32'd1);
    chk("t3_relock_cnt", {24'd0, relock_cnt}, 32'd1);
    chk("t3_locked_clr", {31'd0, locked}, 32'd0);
    chk("t3_init_clr", {31'd0, init_done}, 32'd0);
    tick(7);
    lock = 1'b1;
    tick(14);
    chk("t3_relock_held", {31'd0, rst_out}, 32'd1);
    tick(1);
    chk("t3_relock_fall", {31'd0, rst_out}, 32'd0);
    tick(19);
    chk("t3_reinit_early", {31'd0, init_done}, 32'd0);
    tick(1);
    chk("t3_reinit_done", {31'd0, init_done}, 32'd1);
    chk("t3_lost_sticky", {31'd0, lock_lost}, 32'd1);
    clr_lost = 1'b1;
    tick(1);
    clr_lost = 1'b0;
    chk("t3_clr_lost", {31'd0, lock_lost}, 32'd0);
    chk("t3_clr_keeps_cnt", {24'd0, relock_cnt}, 32'd1);

    // Test 2: lock low one clock in five never passes the filter
    do_reset();
    for (int i = 0; i < 200; i++) begin
      lock = (i % 5 != 4);
      tick(1);
      chk("t2_rst_out", {31'd0, rst_out}, 32'd1);
      chk("t2_locked", {31'd0, locked}, 32'd0);
    end

    // Test 4: loss during INIT is not counted
    do_reset();
    lock = 1'b1;
    tick(15);
    chk("t4_in_init", {31'd0, rst_out}, 32'd0);
    tick(5);
    lock = 1'b0;
    tick(3);
    chk("t4_rst_out", {31'd0, rst_out}, 32'd1);
    chk("t4_locked", {31'd0, locked}, 32'd0);
    chk("t4_lock_lost", {31'd0, lock_lost}, 32'd0);
    chk("t4_relock_cnt", {24'd0, relock_cnt}, 32'd0);

    // Test 5: 300 RUN losses saturate relock_cnt
    do_reset();
    for (int k = 0; k < 300; k++) begin
      lock = 1'b1;
      wait_init("t5_reach_run");
      lock = 1'b0;
      tick(3);
      if (k == 254) chk("t5_cnt_at_255", {24'd0, relock_cnt}, 32'd255);
    end
    chk("t5_cnt_sat", {24'd0, relock_cnt}, 32'd255);
    chk("t5_lost_set", {31'd0, lock_lost}, 32'd1);
    clr_lost = 1'b1;
    tick(1);
    clr_lost = 1'b0;
    chk("t5_clr_lost", {31'd0, lock_lost}, 32'd0);
    chk("t5_cnt_kept", {24'd0, relock_cnt}, 32'd255);
    lock = 1'b1;
    wait_init("t5_reach_run2");
    lock = 1'b0;
    tick(2);
    clr_lost = 1'b1;
    tick(1);
    clr_lost = 1'b0;
    chk("t5_set_wins", {31'd0, lock_lost}, 32'd1);
    chk("t5_set_wins_rst", {31'd0, rst_out}, 32'd1);

    // Test 6: asynchronous rst mid-INIT
    lock = 1'b1;
    tick(20);
    chk("t6_in_init", {31'd0, rst_out}, 32'd0);
    chk("t6_locked_pre", {31'd0, locked}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("t6_rst_out", {31'd0, rst_out}, 32'd1);
    chk("t6_init_done", {31'd0, init_done}, 32'd0);
    chk("t6_locked", {31'd0, locked}, 32'd0);
    chk("t6_lock_lost", {31'd0, lock_lost}, 32'd0);
    chk("t6_relock_cnt", {24'd0, relock_cnt}, 32'd0);
    tick(1);
    rst = 1'b0;
    tick(14);
    chk("t6_restart_held", {31'd0, rst_out}, 32'd1);
    tick(1);
    chk("t6_restart_fall", {31'd0, rst_out}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
